// File: rtl/dec_sel_pkg.sv
// +------------------------------------------------------------------+
// | dec_sel_pkg: shared types and widths for the decoder arbiter     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package dec_sel_pkg;

  localparam int ADDR_W = 3;
  localparam int SEL_W  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic logic [SEL_W-1:0] decode_sel(input logic [ADDR_W-1:0] addr);
    decode_sel       = '0;
    decode_sel[addr] = 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dec_sel_arbiter_if.sv
// +------------------------------------------------------------------+
// | dec_sel_arbiter_if: requester bus and decoder outputs            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface dec_sel_arbiter_if #(
  parameter int N_REQ = 4
);
  import dec_sel_pkg::*;

  logic [N_REQ-1:0]        req;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]        gnt;
  logic                    dec_a;
  logic                    dec_b;
  logic                    dec_c;
  logic                    dec_e;
  logic [SEL_W-1:0]        sel;
  logic                    busy;

  modport master (
    output req, req_addr,
    input  gnt, dec_a, dec_b, dec_c, dec_e, sel, busy
  );

  modport slave (
    input  req, req_addr,
    output gnt, dec_a, dec_b, dec_c, dec_e, sel, busy
  );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting after last   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  int idx;

  // Scan last+1 .. last+N_REQ with wrap; the first set request wins.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!any_req && req[IDX_W'(idx)]) begin
        any_req = 1'b1;
        winner  = IDX_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dec_sel_arbiter.sv
// +------------------------------------------------------------------+
// | dec_sel_arbiter: round-robin sharing of one 3-to-8 select decoder|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dec_sel_arbiter
  import dec_sel_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dec_sel_arbiter_if.slave bus
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  state_t             r_state;
  logic [IDX_W-1:0]   r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_en;
  logic [N_REQ-1:0]   r_gnt;
  logic [SEL_W-1:0]   r_sel;

  logic [IDX_W-1:0]   w_winner;
  logic               w_any_req;
  logic [ADDR_W-1:0]  w_win_addr;
  logic               w_release;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_rr (
    .req     (bus.req),
    .last    (r_last),
    .winner  (w_winner),
    .any_req (w_any_req)
  );

  assign w_win_addr = bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];

  // While holding, r_last is the granted requester.
  assign w_release = !bus.req[r_last] || (r_cnt == HOLD_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(N_REQ - 1);
      r_cnt   <= '0;
      r_addr  <= '0;
      r_en    <= 1'b0;
      r_gnt   <= '0;
      r_sel   <= '0;
    end else begin
      unique case (r_state)
        IDLE, GAP: begin
          if (w_any_req) begin
            r_state <= HOLD;
            r_last  <= w_winner;
            r_cnt   <= CNT_W'(1);
            r_addr  <= w_win_addr;
            r_en    <= 1'b1;
            r_gnt   <= N_REQ'(1) << w_winner;
            r_sel   <= decode_sel(w_win_addr);
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_gnt   <= '0;
            r_sel   <= '0;
          end
        end
        HOLD: begin
          // Drop and timeout on the same edge still yield a single GAP.
          if (w_release) begin
            r_state <= GAP;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_gnt   <= '0;
            r_sel   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_addr  <= '0;
          r_en    <= 1'b0;
          r_gnt   <= '0;
          r_sel   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.dec_a = r_addr[2];
  assign bus.dec_b = r_addr[1];
  assign bus.dec_c = r_addr[0];
  assign bus.dec_e = r_en;
  assign bus.sel   = r_sel;
  assign bus.busy  = (r_state == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_dec_sel_arbiter.sv
// +------------------------------------------------------------------+
// | tb_dec_sel_arbiter: scoreboard bench for dec_sel_arbiter         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dec_sel_arbiter;

  localparam int N = 4;

  typedef logic [16:0] exp_t;
  localparam exp_t ZERO = '0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  dec_sel_arbiter_if #(.N_REQ(N)) bus_a ();
  dec_sel_arbiter_if #(.N_REQ(N)) bus_b ();

  dec_sel_arbiter #(.N_REQ(N), .HOLD_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  dec_sel_arbiter #(.N_REQ(N), .HOLD_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Expected output word {gnt, a, b, c, e, sel, busy} for an active grant.
  function automatic exp_t mk(input logic [3:0] g, input logic [2:0] a);
    logic [7:0] s;
    s    = 8'h00;
    s[a] = 1'b1;
    return {g, a, 1'b1, s, 1'b1};
  endfunction

  function automatic exp_t obs_a();
    return {bus_a.gnt, bus_a.dec_a, bus_a.dec_b, bus_a.dec_c, bus_a.dec_e, bus_a.sel, bus_a.busy};
  endfunction

  function automatic exp_t obs_b();
    return {bus_b.gnt, bus_b.dec_a, bus_b.dec_b, bus_b.dec_c, bus_b.dec_e, bus_b.sel, bus_b.busy};
  endfunction

  task automatic test_reset();
    exp_t got, want;
    rst_n          = 1'b0;
    bus_a.req      = 4'b1111;
    bus_a.req_addr = '0;
    for (int c = 0; c < 2; c++) begin
      sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", c, got, want);
      end
    end
    rst_n = 1'b1;
    sb_q.push_back(mk(4'b0001, 3'd0));
    @(posedge clk); #1;
    got = obs_a(); want = sb_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_first_grant got=%h exp=%h", got, want);
    end
    bus_a.req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_drain cyc%0d got=%h exp=%h", c, got, want);
      end
    end
  endtask

  task automatic test_single();
    exp_t got, want;
    bus_a.req      = 4'b0001;
    bus_a.req_addr = {3'd0, 3'd0, 3'd0, 3'b101};
    for (int c = 0; c < 8; c++) begin
      if (c == 6) bus_a.req = 4'b0000;
      if (c < 4 || c == 5) sb_q.push_back(mk(4'b0001, 3'b101));
      else                 sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL single cyc%0d got=%h exp=%h", c, got, want);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t got, want;
    logic [2:0] rr_addr [4];
    int w;
    rr_addr = '{3'd0, 3'd2, 3'd4, 3'd7};
    rst_n = 1'b0;
    sb_q.push_back(ZERO);
    @(posedge clk); #1;
    got = obs_a(); want = sb_q.pop_front(); checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL rr_reset got=%h exp=%h", got, want);
    end
    rst_n          = 1'b1;
    bus_a.req      = 4'b1111;
    bus_a.req_addr = {3'd7, 3'd4, 3'd2, 3'd0};
    for (int c = 0; c < 26; c++) begin
      // Drop every request on the same edge the fifth grant times out.
      if (c == 24) bus_a.req = 4'b0000;
      w = (c / 5) % 4;
      if (c < 25 && (c % 5) < 4) sb_q.push_back(mk(4'(1 << w), rr_addr[w]));
      else                       sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL round_robin cyc%0d got=%h exp=%h", c, got, want);
      end
    end
  endtask

  task automatic test_early_release();
    exp_t got, want;
    bus_a.req      = 4'b0100;
    bus_a.req_addr = {3'd0, 3'b011, 3'd0, 3'd0};
    for (int c = 0; c < 4; c++) begin
      if (c < 2) sb_q.push_back(mk(4'b0100, 3'b011));
      else       sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL early_release cyc%0d got=%h exp=%h", c, got, want);
      end
      if (c == 0) bus_a.req_addr = {3'd0, 3'b110, 3'd0, 3'd0};
      if (c == 1) bus_a.req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_hold();
    exp_t got, want;
    bus_a.req      = 4'b0011;
    bus_a.req_addr = {3'd0, 3'd0, 3'b001, 3'b101};
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst_n = 1'b0;
      if (c == 3) rst_n = 1'b1;
      if (c == 4) bus_a.req = 4'b0000;
      if (c == 2 || c >= 4) sb_q.push_back(ZERO);
      else                  sb_q.push_back(mk(4'b0001, 3'b101));
      @(posedge clk); #1;
      got = obs_a(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_hold cyc%0d got=%h exp=%h", c, got, want);
      end
    end
  endtask

  task automatic test_hold_one();
    exp_t got, want;
    bus_b.req      = 4'b0011;
    bus_b.req_addr = {3'd0, 3'd0, 3'b010, 3'b001};
    for (int c = 0; c < 7; c++) begin
      if (c == 5) bus_b.req = 4'b0000;
      if (c == 0 || c == 4) sb_q.push_back(mk(4'b0001, 3'b001));
      else if (c == 2)      sb_q.push_back(mk(4'b0010, 3'b010));
      else                  sb_q.push_back(ZERO);
      @(posedge clk); #1;
      got = obs_b(); want = sb_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL hold_one cyc%0d got=%h exp=%h", c, got, want);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req      = '0;
    bus_a.req_addr = '0;
    bus_b.req      = '0;
    bus_b.req_addr = '0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_reset_mid_hold();
    test_hold_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dec_sel_arbiter.md
# dec_sel_arbiter

Round-robin arbiter and sequencer that shares one 3-to-8 select decoder among several requesters. Each requester asks for one of eight targets. The block grants one requester at a time and drives the decoder inputs (A/B/C address, E enable) for a bounded hold window. It also produces the one-hot decoded select directly. Between grants it inserts a dead cycle so that two target selects never overlap.

## Interface
Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- HOLD_CYCLES, 4, maximum cycles a grant is held; legal range 1..255.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  level request, bit i = requester i.
- req_addr  in  3*N_REQ  target of requester i at bits [3i+2:3i], MSB first.
- gnt  out  N_REQ  one-hot grant, registered.
- dec_a  out  1  decoder address MSB.
- dec_b  out  1  decoder address middle bit.
- dec_c  out  1  decoder address LSB.
- dec_e  out  1  decoder enable, high only while a grant is held.
- sel  out  8  one-hot select; sel[k]=1 iff dec_e and {dec_a,dec_b,dec_c}==k.
- busy  out  1  high in HOLD state.

## Operation
- States: IDLE, HOLD, GAP.
- IDLE:
  - If no req is high, stay in IDLE.
  - Otherwise pick winner w by round-robin and go to HOLD.
  - On entry to HOLD, latch req_addr[w], set gnt=1<<w, set dec_e=1, set cnt=1, set last=w.
- Round-robin rule:
  - Search starts at index (last+1) mod N_REQ and increases with wrap-around.
  - The first set req bit wins.
  - last resets to N_REQ-1, so requester 0 has top priority after reset.
- HOLD:
  - If req[w]==0, or cnt==HOLD_CYCLES, go to GAP.
  - Otherwise cnt increments.
  - req_addr and the other req bits are ignored while in HOLD; the address stays latched.
- GAP:
  - All of gnt, dec_e, sel and busy are 0 for exactly one cycle.
  - dec_a/b/c also clear to 0 in GAP.
  - Arbitration runs in GAP exactly as in IDLE; a pending request goes straight to HOLD.
  - With no request pending, GAP goes to IDLE.
- Counter: 8 bits; it never exceeds HOLD_CYCLES.
- Reset values: gnt=0, dec_a=dec_b=dec_c=0, dec_e=0, sel=0, busy=0, state=IDLE, cnt=0, last=N_REQ-1.

## Timing
- Latency: req high at edge t in IDLE or GAP gives gnt, dec_* and sel valid after edge t (one cycle).
- Hold length with req held continuously: gnt high for exactly HOLD_CYCLES cycles, then one GAP cycle.
- Early release:
  - req[w] sampled low at a HOLD edge clears all outputs after that edge.
  - A grant is always at least 1 cycle long.
- Simultaneous requests: resolved only by round-robin order; a requester holding req high is served within N_REQ grants.
- Simultaneous drop and timeout on the same edge: go to GAP once; no extra cycle.
- Reset mid-HOLD: the next edge with rst_n=0 forces all reset values; the grant is not resumed.
- Outputs are all registered; there is no combinational path from req to any output.

## Structure
- Package dec_sel_pkg holds:
  - the state enum (IDLE, HOLD, GAP);
  - ADDR_W=3;
  - SEL_W=8;
  - CNT_W=8.
- Sub-module rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req, last.
  - Outputs: winner index, any_req.
  - Parameterised by N_REQ.
- Top level holds the FSM, counter, address latch and registered decode to sel.

## Test plan
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> all outputs 0 and busy=0. After release, the first grant is gnt=4'b0001.
- Single requester: req=4'b0001 held, addr0=3'b101 ->
  - gnt=0001, abc=101, dec_e=1, sel=8'b0010_0000 for 4 cycles;
  - then 1 cycle with all outputs 0;
  - then regrant.
- Round-robin: req=4'b1111 held, addrs 0,2,4,7 ->
  - grant order 0,1,2,3,0;
  - sel sequence 8'h01, 8'h04, 8'h10, 8'h80, 8'h01;
  - one zero GAP cycle between each grant.
- Early release and address freeze: requester 2 is granted with addr=3'b011. During the hold, req_addr is changed to 3'b110, then req[2] drops after 2 grant cycles ->
  - sel stays 8'h08 throughout;
  - gnt high exactly 2 cycles.
- Reset mid-HOLD: rst_n=0 for one edge at cnt=2 ->
  - all outputs 0 next cycle;
  - requester 0 is granted first afterwards.
- HOLD_CYCLES=1, req=4'b0011 held -> gnt alternates 0001, 0, 0010, 0, each asserted for exactly 1 cycle.
